// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: maze player FSM owning position, lives, freeze, goal and obstacle lookup handshake
module maze_player_ctrl #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int GOAL_X = 159,
  parameter int GOAL_Y = 119,
  parameter int OBS_LAT = 1,
  parameter int LIVES = 3,
  parameter int FREEZE_T = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [2:0]    move,
  output logic          obs_req,
  output logic [XW-1:0] obs_x,
  output logic [YW-1:0] obs_y,
  input  logic [1:0]    obs_code,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          plot,
  output logic [1:0]    s_color,
  output logic [2:0]    lives,
  output logic          won,
  output logic          lost,
  output logic [3:0]    state_cur
);
  typedef enum logic [3:0] {
    CLEAR, WAIT, ERASE, QUERY, WAIT_OBS, TEST, MOVE, DRAW, FROZEN, HIT, WIN, LOSE
  } state_t;
  localparam logic [XW-1:0] XM = XW'(X_MAX);
  localparam logic [YW-1:0] YM = YW'(Y_MAX);
  localparam logic [XW-1:0] XS = XW'(X_START);
  localparam logic [YW-1:0] YS = YW'(Y_START);
  localparam logic [XW-1:0] GX = XW'(GOAL_X);
  localparam logic [YW-1:0] GY = YW'(GOAL_Y);
  localparam logic [XW-1:0] X1 = XW'(1);
  localparam logic [YW-1:0] Y1 = YW'(1);
  localparam logic [2:0] L0 = 3'(LIVES);
  localparam logic [3:0] FT = 4'(FREEZE_T);
  localparam logic [7:0] W1 = 8'(OBS_LAT - 1);
  state_t state;
  logic [2:0] mv_r;
  logic fz;
  logic [3:0] fcnt;
  logic [7:0] wcnt;
  logic oob;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  always_comb begin
    oob = (mv_r == 3'd1 && xpos == '0) || (mv_r == 3'd2 && xpos == XM) ||
          (mv_r == 3'd3 && ypos == '0) || (mv_r == 3'd4 && ypos == YM);
    tx = mv_r == 3'd1 ? xpos - X1 : mv_r == 3'd2 ? xpos + X1 : xpos;
    ty = mv_r == 3'd3 ? ypos - Y1 : mv_r == 3'd4 ? ypos + Y1 : ypos;
    plot = state inside {CLEAR, ERASE, DRAW, FROZEN, LOSE, WIN};
    s_color = state == DRAW ? 2'd1 : state == FROZEN ? 2'd2 : state == LOSE ? 2'd3 : 2'd0;
  end
  assign state_cur = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      xpos <= XS;
      ypos <= YS;
      lives <= L0;
      fcnt <= '0;
      fz <= 1'b0;
      won <= 1'b0;
      lost <= 1'b0;
      obs_req <= 1'b0;
      obs_x <= XS;
      obs_y <= YS;
      mv_r <= '0;
      wcnt <= '0;
    end else begin
      obs_req <= 1'b0;
      case (state)
        CLEAR: state <= WAIT;
        WAIT: if (tick) state <= ERASE;
        ERASE: begin
          mv_r <= move > 3'd4 ? 3'd0 : move;
          state <= (move == 3'd0 || move > 3'd4) ? DRAW : QUERY;
        end
        QUERY: if (oob) state <= DRAW;
        else begin
          obs_x <= tx;
          obs_y <= ty;
          obs_req <= 1'b1;
          wcnt <= W1;
          state <= WAIT_OBS;
        end
        WAIT_OBS: if (wcnt == 8'd0) state <= TEST; else wcnt <= wcnt - 8'd1;
        TEST: begin
          fz <= obs_code == 2'd3;
          state <= obs_code == 2'd1 ? DRAW : obs_code == 2'd2 ? HIT : MOVE;
        end
        MOVE: begin
          xpos <= obs_x;
          ypos <= obs_y;
          fcnt <= FT;
          state <= fz ? FROZEN : DRAW;
        end
        FROZEN: if (tick) begin
          fcnt <= fcnt - 4'd1;
          if (fcnt <= 4'd1) state <= DRAW;
        end
        HIT: if (lives <= 3'd1) begin
          lives <= '0;
          lost <= 1'b1;
          state <= LOSE;
        end else begin
          lives <= lives - 3'd1;
          xpos <= XS;
          ypos <= YS;
          state <= DRAW;
        end
        DRAW: if (xpos == GX && ypos == GY) begin
          won <= 1'b1;
          state <= WIN;
        end else state <= WAIT;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: directed self-checking bench for maze_player_ctrl on a 4x3 maze
module tb_maze_player_ctrl;
  localparam int LAT = 3;
  localparam logic [3:0] S_CLEAR = 0, S_WAIT = 1, S_WOBS = 4, S_DRAW = 7, S_FROZEN = 8,
                         S_WIN = 10, S_LOSE = 11;
  logic clk, reset, tick, obs_req, plot, won, lost;
  logic [2:0] move, lives;
  logic [7:0] obs_x, xpos;
  logic [6:0] obs_y, ypos;
  logic [1:0] obs_code, s_color;
  logic [3:0] state_cur;
  logic [1:0] cmap [0:3][0:2];
  int k = 15;
  int reqs = 0;
  int checks = 0;
  int errors = 0;
  int r0;
  maze_player_ctrl #(.XW(8), .YW(7), .X_MAX(3), .Y_MAX(2), .X_START(0), .Y_START(0),
    .GOAL_X(3), .GOAL_Y(2), .OBS_LAT(LAT), .LIVES(2), .FREEZE_T(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .move(move), .obs_req(obs_req), .obs_x(obs_x),
    .obs_y(obs_y), .obs_code(obs_code), .xpos(xpos), .ypos(ypos), .plot(plot),
    .s_color(s_color), .lives(lives), .won(won), .lost(lost), .state_cur(state_cur));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    k <= obs_req ? 0 : (k < 15 ? k + 1 : k);
    if (obs_req) reqs <= reqs + 1;
  end
  assign obs_code = (k == LAT) ? cmap[obs_x[1:0]][obs_y[1:0]] : ~cmap[obs_x[1:0]][obs_y[1:0]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (state_cur !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_cur), 32'(s));
  endtask
  task automatic pulse(input logic [2:0] m);
    move = m;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask
  task automatic do_move(input logic [2:0] m, input logic [3:0] s, input string tag);
    wait_state(S_WAIT, {tag, "_idle"});
    r0 = reqs;
    pulse(m);
    wait_state(s, tag);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic clear_map();
    for (int x = 0; x < 4; x++) for (int y = 0; y < 3; y++) cmap[x][y] = 2'd0;
  endtask
  initial begin
    clear_map();
    reset = 1'b1;
    tick = 1'b0;
    move = 3'd0;
    idle(2);
    chk("rst_state", 32'(state_cur), 32'(S_CLEAR));
    chk("rst_pos", {xpos, 1'b0, ypos}, 32'd0);
    chk("rst_lives", 32'(lives), 32'd2);
    chk("rst_plot", {plot, s_color, obs_req, won, lost}, 32'b100000);
    reset = 1'b0;
    @(negedge clk);
    chk("clr_to_wait", 32'(state_cur), 32'(S_WAIT));
    chk("wait_noplot", 32'(plot), 32'd0);
    do_move(3'd2, S_DRAW, "t1_draw");
    chk("t1_req", 32'(reqs - r0), 32'd1);
    chk("t1_obs", {obs_x, 1'b0, obs_y}, {8'd1, 1'b0, 7'd0});
    chk("t1_pos", {xpos, 1'b0, ypos}, {8'd1, 1'b0, 7'd0});
    chk("t1_col", {plot, s_color}, 32'b101);
    @(negedge clk);
    chk("t1_wait", 32'(state_cur), 32'(S_WAIT));
    do_move(3'd1, S_DRAW, "t2_back");
    chk("t2_back_x", 32'(xpos), 32'd0);
    do_move(3'd1, S_DRAW, "t2_left0");
    chk("t2_left_req", 32'(reqs - r0), 32'd0);
    chk("t2_left_pos", {xpos, 1'b0, ypos}, 32'd0);
    do_move(3'd3, S_DRAW, "t2_up0");
    chk("t2_up_req", 32'(reqs - r0), 32'd0);
    chk("t2_up_pos", {xpos, 1'b0, ypos}, 32'd0);
    do_move(3'd5, S_DRAW, "t2_m5");
    chk("t2_m5_req", 32'(reqs - r0), 32'd0);
    @(negedge clk);
    chk("t2_wait", 32'(state_cur), 32'(S_WAIT));
    cmap[1][0] = 2'd3;
    do_move(3'd2, S_FROZEN, "t4_frozen");
    chk("t4_pos", {xpos, 1'b0, ypos}, {8'd1, 1'b0, 7'd0});
    chk("t4_col", {plot, s_color}, 32'b110);
    move = 3'd4;
    for (int i = 0; i < 3; i++) begin
      pulse(3'd4);
      idle(2);
      chk("t4_still", 32'(state_cur), 32'(S_FROZEN));
    end
    chk("t4_ypos", 32'(ypos), 32'd0);
    pulse(3'd4);
    chk("t4_draw", 32'(state_cur), 32'(S_DRAW));
    chk("t4_pos2", {xpos, 1'b0, ypos}, {8'd1, 1'b0, 7'd0});
    move = 3'd0;
    cmap[1][0] = 2'd0;
    cmap[1][1] = 2'd2;
    do_move(3'd4, S_DRAW, "t3_hit1");
    chk("t3_lives1", 32'(lives), 32'd1);
    chk("t3_restart", {xpos, 1'b0, ypos}, 32'd0);
    do_move(3'd2, S_DRAW, "t3_right");
    do_move(3'd4, S_LOSE, "t3_lose");
    chk("t3_lives0", 32'(lives), 32'd0);
    chk("t3_lost", {lost, won}, 32'b10);
    chk("t3_col", {plot, s_color}, 32'b111);
    pulse(3'd1);
    idle(6);
    chk("t3_term", {state_cur, lives, xpos}, {S_LOSE, 3'd0, 8'd1});
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_map();
    cmap[1][0] = 2'd1;
    wait_state(S_WAIT, "t5_rst");
    chk("t5_rst_lives", {lives, lost}, {3'd2, 1'b0});
    do_move(3'd2, S_DRAW, "t5_wall");
    chk("t5_wall_x", 32'(xpos), 32'd0);
    chk("t5_wall_req", 32'(reqs - r0), 32'd1);
    cmap[1][0] = 2'd0;
    wait_state(S_WAIT, "t5_idle");
    pulse(3'd2);
    wait_state(S_WOBS, "t5_wobs");
    reset = 1'b1;
    @(negedge clk);
    chk("t5_mid_rst", {state_cur, xpos, obs_req}, {S_CLEAR, 8'd0, 1'b0});
    reset = 1'b0;
    idle(6);
    chk("t5_ignored", {state_cur, xpos, ypos}, {S_WAIT, 8'd0, 7'd0});
    do_move(3'd2, S_DRAW, "t6_r1");
    do_move(3'd2, S_DRAW, "t6_r2");
    do_move(3'd2, S_DRAW, "t6_r3");
    chk("t6_x3", 32'(xpos), 32'd3);
    do_move(3'd2, S_DRAW, "t6_rmax");
    chk("t6_rmax_req", 32'(reqs - r0), 32'd0);
    chk("t6_rmax_x", 32'(xpos), 32'd3);
    do_move(3'd4, S_DRAW, "t6_d1");
    @(negedge clk);
    chk("t6_notwon", {state_cur, won}, {S_WAIT, 1'b0});
    do_move(3'd4, S_WIN, "t6_win");
    chk("t6_won", {won, lost}, 32'b10);
    chk("t6_pos", {xpos, 1'b0, ypos}, {8'd3, 1'b0, 7'd2});
    chk("t6_col", {plot, s_color}, 32'b100);
    pulse(3'd1);
    idle(6);
    chk("t6_term", {state_cur, xpos, ypos, lives}, {S_WIN, 8'd3, 7'd2, 3'd2});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
